// File: rtl/cp0_regfile_if.sv
// Pipeline-to-CP0 bus: MTC0/MFC0 access, exception/ERET commit strobes and live status outputs.
// we, exc_valid and eret are single-cycle qualifiers with no ready: CP0 always accepts on the edge they are high.
interface cp0_regfile_if #(
  parameter int NUM_HW_INT = 6
);
  logic                  we;
  logic [4:0]            waddr;
  logic [2:0]            wsel;
  logic [31:0]           wdata;
  logic [4:0]            raddr;
  logic [2:0]            rsel;
  logic [31:0]           rdata;
  logic [NUM_HW_INT-1:0] hw_int;
  logic                  exc_valid;
  logic [4:0]            exc_code;
  logic [31:0]           exc_pc;
  logic                  exc_bd;
  logic                  exc_bad_valid;
  logic [31:0]           exc_badvaddr;
  logic                  eret;
  logic                  int_pending;
  logic [31:0]           status_out;
  logic [31:0]           cause_out;
  logic [31:0]           epc_out;

  modport master (
    output we, waddr, wsel, wdata, raddr, rsel, hw_int,
    output exc_valid, exc_code, exc_pc, exc_bd, exc_bad_valid, exc_badvaddr, eret,
    input  rdata, int_pending, status_out, cause_out, epc_out
  );

  modport slave (
    input  we, waddr, wsel, wdata, raddr, rsel, hw_int,
    input  exc_valid, exc_code, exc_pc, exc_bd, exc_bad_valid, exc_badvaddr, eret,
    output rdata, int_pending, status_out, cause_out, epc_out
  );
endinterface

// File: rtl/cp0_regfile.sv
// MIPS32-style CP0 subset: BadVAddr, Count/Compare timer, Status, Cause, EPC and PRId,
// with exception/ERET commit handling and interrupt request generation.
module cp0_regfile #(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] PRID       = 32'h0001_8000
) (
  input logic          clk,
  input logic          rst,
  cp0_regfile_if.slave bus
);

  localparam int                DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [31:0]      r_badvaddr;
  logic [31:0]      r_count;
  logic [31:0]      r_compare;
  logic [31:0]      r_epc;
  logic [DIV_W-1:0] r_div;
  logic             r_ie;
  logic             r_exl;
  logic [7:0]       r_im;
  logic             r_bd;
  logic             r_ti;
  logic [1:0]       r_sw;
  logic [4:0]       r_exccode;
  logic [5:0]       r_hw;

  logic             w_wr_sel0;
  logic             w_wr_count;
  logic             w_wr_compare;
  logic             w_wr_status;
  logic             w_wr_cause;
  logic             w_wr_epc;
  logic             w_tick;
  logic [31:0]      w_count_inc;
  logic [5:0]       w_hw_ext;
  logic [7:0]       w_ip;
  logic [31:0]      w_status;
  logic [31:0]      w_cause;
  logic [31:0]      w_rdata;

  assign w_wr_sel0    = bus.we && (bus.wsel == 3'd0);
  assign w_wr_count   = w_wr_sel0 && (bus.waddr == 5'd9);
  assign w_wr_compare = w_wr_sel0 && (bus.waddr == 5'd11);
  assign w_wr_status  = w_wr_sel0 && (bus.waddr == 5'd12);
  assign w_wr_cause   = w_wr_sel0 && (bus.waddr == 5'd13);
  assign w_wr_epc     = w_wr_sel0 && (bus.waddr == 5'd14);

  assign w_tick      = (r_div == DIV_LAST);
  assign w_count_inc = r_count + 32'd1;

  // Absent interrupt lines are tied low so IP reads 0 in their positions.
  always_comb begin
    w_hw_ext                 = '0;
    w_hw_ext[NUM_HW_INT-1:0] = bus.hw_int;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hw <= '0;
    end else begin
      r_hw <= w_hw_ext;
    end
  end

  // MTC0 Count restarts the prescaler so the next increment is a full COUNT_DIV away.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_div   <= '0;
    end else if (w_wr_count) begin
      r_count <= bus.wdata;
      r_div   <= '0;
    end else if (w_tick) begin
      r_count <= w_count_inc;
      r_div   <= '0;
    end else begin
      r_div   <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_compare <= '0;
    end else if (w_wr_compare) begin
      r_compare <= bus.wdata;
    end
  end

  // Writing Compare acknowledges the timer; that clear beats a coincident match.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ti <= 1'b0;
    end else if (w_wr_compare) begin
      r_ti <= 1'b0;
    end else if (w_tick && !w_wr_count && (w_count_inc == r_compare)) begin
      r_ti <= 1'b1;
    end
  end

  // Later assignments override earlier ones: MTC0, then ERET, then exception.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie  <= 1'b0;
      r_exl <= 1'b0;
      r_im  <= '0;
    end else begin
      if (w_wr_status) begin
        r_ie  <= bus.wdata[0];
        r_exl <= bus.wdata[1];
        r_im  <= bus.wdata[15:8];
      end
      if (bus.exc_valid) begin
        r_exl <= 1'b1;
      end else if (bus.eret) begin
        r_exl <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bd      <= 1'b0;
      r_sw      <= '0;
      r_exccode <= '0;
    end else begin
      if (w_wr_cause) begin
        r_sw <= bus.wdata[9:8];
      end
      if (bus.exc_valid) begin
        r_exccode <= bus.exc_code;
        if (!r_exl) begin
          r_bd <= bus.exc_bd;
        end
      end
    end
  end

  // A nested exception (EXL already set) leaves EPC alone, so MTC0 EPC still lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_epc <= '0;
    end else if (bus.exc_valid && !r_exl) begin
      r_epc <= bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
    end else if (w_wr_epc) begin
      r_epc <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_badvaddr <= '0;
    end else if (bus.exc_valid && bus.exc_bad_valid) begin
      r_badvaddr <= bus.exc_badvaddr;
    end
  end

  assign w_ip     = {r_hw[5] | r_ti, r_hw[4:0], r_sw};
  assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign w_cause  = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};

  always_comb begin
    w_rdata = '0;
    if (bus.rsel == 3'd0) begin
      case (bus.raddr)
        5'd8:    w_rdata = r_badvaddr;
        5'd9:    w_rdata = r_count;
        5'd11:   w_rdata = r_compare;
        5'd12:   w_rdata = w_status;
        5'd13:   w_rdata = w_cause;
        5'd14:   w_rdata = r_epc;
        5'd15:   w_rdata = PRID;
        default: w_rdata = '0;
      endcase
    end
  end

  assign bus.rdata       = w_rdata;
  assign bus.status_out  = w_status;
  assign bus.cause_out   = w_cause;
  assign bus.epc_out     = r_epc;
  assign bus.int_pending = r_ie && !r_exl && (|(w_ip & r_im));

endmodule
